// File: rtl/lvds_pkg.sv
// lvds_pkg: shared state encoding, word width, default training pattern and clog2 helper
package lvds_pkg;
    localparam int LANE_W = 7;
    localparam logic [LANE_W-1:0] DEF_TRAIN_PATTERN = 7'b110_0011;
    typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, NEXT, DONE} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/lvds_lane_mux.sv
// lvds_lane_mux: registers the gearbox word of the selected lane
module lvds_lane_mux
    import lvds_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int SEL_W     = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [LANE_W*NUM_LANES-1:0] i_lane_data,
    input  logic [SEL_W-1:0]            i_sel,
    output logic [LANE_W-1:0]           o_word
);
    logic [LANE_W-1:0] w_words [NUM_LANES];
    logic [LANE_W-1:0] r_word;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_slice
        assign w_words[i] = i_lane_data[LANE_W*i +: LANE_W];
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_word <= '0;
        else r_word <= w_words[i_sel];
    end
    assign o_word = r_word;
endmodule

// File: rtl/lvds_lane_align_ctrl.sv
// lvds_lane_align_ctrl: sequences lanes through pattern check and gearbox slips until each locks or fails
module lvds_lane_align_ctrl
    import lvds_pkg::*;
#(
    parameter int                NUM_LANES     = 4,
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                MATCH_COUNT   = 8,
    parameter int                SLIP_WAIT     = 6,
    parameter int                MAX_SLIPS     = 14,
    localparam int               LW = (clog2(NUM_LANES) < 1) ? 1 : clog2(NUM_LANES)
) (
    input  logic                        i_px_clk,
    input  logic                        i_px_reset,
    input  logic                        i_px_ready,
    input  logic                        i_realign,
    input  logic [LANE_W*NUM_LANES-1:0] i_lane_data,
    output logic [NUM_LANES-1:0]        o_lane_slip,
    output logic [NUM_LANES-1:0]        o_lane_aligned,
    output logic [LW-1:0]               o_cur_lane,
    output logic                        o_busy,
    output logic                        o_all_aligned,
    output logic                        o_align_error,
    output logic [LW-1:0]               o_err_lane
);
    localparam int MW = clog2(MATCH_COUNT + 1);
    localparam int SW = clog2(MAX_SLIPS + 1);

    state_t               r_state, w_state_nxt;
    logic [LW-1:0]        r_cur_lane, w_cur_lane_nxt;
    logic [LW-1:0]        r_err_lane, w_err_lane_nxt;
    logic [MW-1:0]        r_match_cnt, w_match_cnt_nxt;
    logic [SW-1:0]        r_slip_cnt, w_slip_cnt_nxt;
    logic [3:0]           r_wait_cnt, w_wait_cnt_nxt;
    logic [NUM_LANES-1:0] r_lane_aligned, w_lane_aligned_nxt;
    logic [NUM_LANES-1:0] r_lane_slip, w_lane_slip_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_all_aligned, w_all_aligned_nxt;
    logic                 r_align_error, w_align_error_nxt;
    logic [LANE_W-1:0]    w_word;
    logic                 w_abort, w_realign, w_match;

    // selecting on the next lane index keeps the registered word in step with r_cur_lane
    lvds_lane_mux #(.NUM_LANES(NUM_LANES), .SEL_W(LW)) u_mux (
        .i_clk       (i_px_clk),
        .i_rst       (i_px_reset),
        .i_lane_data (i_lane_data),
        .i_sel       (w_cur_lane_nxt),
        .o_word      (w_word)
    );

    assign w_abort   = !i_px_ready;
    assign w_realign = i_realign && (r_state != IDLE);
    assign w_match   = (w_word == TRAIN_PATTERN);

    always_ff @(posedge i_px_clk or posedge i_px_reset) begin
        if (i_px_reset) begin
            r_state        <= IDLE;
            r_cur_lane     <= '0;
            r_err_lane     <= '0;
            r_match_cnt    <= '0;
            r_slip_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_lane_aligned <= '0;
            r_lane_slip    <= '0;
            r_busy         <= 1'b0;
            r_all_aligned  <= 1'b0;
            r_align_error  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_lane     <= w_cur_lane_nxt;
            r_err_lane     <= w_err_lane_nxt;
            r_match_cnt    <= w_match_cnt_nxt;
            r_slip_cnt     <= w_slip_cnt_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_lane_aligned <= w_lane_aligned_nxt;
            r_lane_slip    <= w_lane_slip_nxt;
            r_busy         <= w_busy_nxt;
            r_all_aligned  <= w_all_aligned_nxt;
            r_align_error  <= w_align_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cur_lane_nxt     = r_cur_lane;
        w_err_lane_nxt     = r_err_lane;
        w_match_cnt_nxt    = r_match_cnt;
        w_slip_cnt_nxt     = r_slip_cnt;
        w_wait_cnt_nxt     = r_wait_cnt;
        w_lane_aligned_nxt = r_lane_aligned;
        w_lane_slip_nxt    = '0;
        w_busy_nxt         = r_busy;
        w_all_aligned_nxt  = r_all_aligned;
        w_align_error_nxt  = r_align_error;
        if (w_abort || w_realign) begin
            w_state_nxt        = IDLE;
            w_cur_lane_nxt     = '0;
            w_err_lane_nxt     = '0;
            w_match_cnt_nxt    = '0;
            w_slip_cnt_nxt     = '0;
            w_wait_cnt_nxt     = '0;
            w_lane_aligned_nxt = '0;
            w_busy_nxt         = 1'b0;
            w_all_aligned_nxt  = 1'b0;
            w_align_error_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_busy_nxt     = 1'b1;
                    w_cur_lane_nxt = '0;
                    w_state_nxt    = CHECK;
                end
                CHECK: begin
                    if (w_match) begin
                        w_match_cnt_nxt = (r_match_cnt == MW'(MATCH_COUNT)) ? r_match_cnt : r_match_cnt + 1'b1;
                        if (r_match_cnt == MW'(MATCH_COUNT - 1)) begin
                            w_lane_aligned_nxt[r_cur_lane] = 1'b1;
                            w_state_nxt = NEXT;
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                        if (r_slip_cnt < SW'(MAX_SLIPS)) begin
                            w_state_nxt = SLIP;
                        end else begin
                            w_err_lane_nxt    = r_align_error ? r_err_lane : r_cur_lane;
                            w_align_error_nxt = 1'b1;
                            w_state_nxt       = NEXT;
                        end
                    end
                end
                SLIP: begin
                    // pulse is registered, so it appears in the first WAIT cycle
                    w_lane_slip_nxt[r_cur_lane] = 1'b1;
                    w_slip_cnt_nxt = (r_slip_cnt == SW'(MAX_SLIPS)) ? r_slip_cnt : r_slip_cnt + 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = WAIT;
                end
                WAIT: begin
                    w_wait_cnt_nxt = (r_wait_cnt == 4'(SLIP_WAIT - 1)) ? r_wait_cnt : r_wait_cnt + 1'b1;
                    w_state_nxt    = (r_wait_cnt == 4'(SLIP_WAIT - 1)) ? CHECK : WAIT;
                end
                NEXT: begin
                    w_match_cnt_nxt = '0;
                    w_slip_cnt_nxt  = '0;
                    if (r_cur_lane == LW'(NUM_LANES - 1)) begin
                        w_busy_nxt        = 1'b0;
                        w_all_aligned_nxt = &r_lane_aligned;
                        w_state_nxt       = DONE;
                    end else begin
                        w_cur_lane_nxt = r_cur_lane + 1'b1;
                        w_state_nxt    = CHECK;
                    end
                end
                DONE: begin
                    w_busy_nxt        = 1'b0;
                    w_all_aligned_nxt = &r_lane_aligned;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_lane_slip    = r_lane_slip;
    assign o_lane_aligned = r_lane_aligned;
    assign o_cur_lane     = r_cur_lane;
    assign o_busy         = r_busy;
    assign o_all_aligned  = r_all_aligned;
    assign o_align_error  = r_align_error;
    assign o_err_lane     = r_err_lane;
endmodule

// File: tb/tb_lvds_lane_align_ctrl.sv
// tb_lvds_lane_align_ctrl: directed checks of lane sequencing, slips, failure, abort, realign and reset
module tb_lvds_lane_align_ctrl;
    localparam int NL = 4;
    localparam logic [6:0] PAT = 7'b110_0011;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          px_reset, px_ready, realign;
    logic [7*NL-1:0] lane_data;
    logic [NL-1:0] lane_slip, lane_aligned;
    logic [1:0]    cur_lane, err_lane;
    logic          busy, all_aligned, align_error;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int slip_lane = 0;
    int need [NL];
    int never [NL];
    int slips [NL];
    int pulses [NL];
    int last_pulse [NL];

    lvds_lane_align_ctrl dut (
        .i_px_clk       (clk),
        .i_px_reset     (px_reset),
        .i_px_ready     (px_ready),
        .i_realign      (realign),
        .i_lane_data    (lane_data),
        .o_lane_slip    (lane_slip),
        .o_lane_aligned (lane_aligned),
        .o_cur_lane     (cur_lane),
        .o_busy         (busy),
        .o_all_aligned  (all_aligned),
        .o_align_error  (align_error),
        .o_err_lane     (err_lane)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int k = 0; k < n; k++) r = {r[5:0], r[6]};
        return r;
    endfunction

    task automatic update_data();
        for (int i = 0; i < NL; i++)
            lane_data[7*i +: 7] = (never[i] != 0) ? 7'h00 : rotl(PAT, (need[i] > slips[i]) ? need[i] - slips[i] : 0);
    endtask

    task automatic set_lanes(input int n0, input int n1, input int n2, input int n3, input int nv);
        need[0] = n0; need[1] = n1; need[2] = n2; need[3] = n3;
        for (int i = 0; i < NL; i++) begin
            never[i] = (i == nv) ? 1 : 0;
            slips[i] = 0;
        end
        update_data();
    endtask

    task automatic new_run(input int lane);
        cyc = 0;
        slip_lane = lane;
        for (int i = 0; i < NL; i++) begin
            pulses[i] = 0;
            last_pulse[i] = -1;
        end
    endtask

    // one px_clk cycle; the gearbox model reacts to slip pulses seen mid-cycle
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NL; i++) begin
            if (lane_slip[i] === 1'b1) begin
                pulses[i]++;
                slips[i]++;
                check("slip_onehot", {28'h0, lane_slip}, 32'(1) << slip_lane);
                if (last_pulse[i] >= 0) check("slip_gap", 32'(cyc - last_pulse[i]), GAP);
                last_pulse[i] = cyc;
            end
        end
        update_data();
    endtask

    task automatic ticks_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        px_reset = 1'b1; px_ready = 1'b0; realign = 1'b0;
        set_lanes(0, 0, 0, 0, -1);
        new_run(0);
        @(negedge clk);
        check("rst_slip", {28'h0, lane_slip}, 0);
        check("rst_aligned", {28'h0, lane_aligned}, 0);
        check("rst_cur_lane", {30'h0, cur_lane}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_all", {31'h0, all_aligned}, 0);
        check("rst_err", {31'h0, align_error}, 0);
        check("rst_err_lane", {30'h0, err_lane}, 0);
        px_reset = 1'b0;
        tick();
        check("idle_no_ready", {31'h0, busy}, 0);

        // all lanes aligned from the start
        px_ready = 1'b1;
        new_run(0);
        ticks_to(1);  check("s1_busy_up", {31'h0, busy}, 1);
        check("s1_lane0", {30'h0, cur_lane}, 0);
        ticks_to(8);  check("s1_al_c8", {28'h0, lane_aligned}, 4'h0);
        ticks_to(9);  check("s1_al_c9", {28'h0, lane_aligned}, 4'h1);
        ticks_to(10); check("s1_lane1", {30'h0, cur_lane}, 1);
        ticks_to(36); check("s1_busy_c36", {31'h0, busy}, 1);
        ticks_to(37); check("s1_busy_c37", {31'h0, busy}, 0);
        check("s1_aligned", {28'h0, lane_aligned}, 4'hF);
        check("s1_all", {31'h0, all_aligned}, 1);
        check("s1_err", {31'h0, align_error}, 0);
        check("s1_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 0);

        // realign from DONE; lane 2 needs three slips
        set_lanes(0, 0, 3, 0, -1);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("s2_clr_aligned", {28'h0, lane_aligned}, 0);
        check("s2_clr_all", {31'h0, all_aligned}, 0);
        check("s2_clr_busy", {31'h0, busy}, 0);
        new_run(2);
        ticks_to(20); check("s2_no_slip_c20", {28'h0, lane_slip}, 0);
        ticks_to(21); check("s2_slip_c21", {28'h0, lane_slip}, 4'h4);
        ticks_to(22); check("s2_slip_c22", {28'h0, lane_slip}, 0);
        ticks_to(60); check("s2_busy_c60", {31'h0, busy}, 1);
        ticks_to(61); check("s2_busy_c61", {31'h0, busy}, 0);
        check("s2_pulses", 32'(pulses[2]), 3);
        check("s2_aligned", {28'h0, lane_aligned}, 4'hF);
        check("s2_all", {31'h0, all_aligned}, 1);

        // lane 1 never matches
        set_lanes(0, 0, 0, 0, 1);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        new_run(1);
        ticks_to(12);  check("s3_slip_c12", {28'h0, lane_slip}, 4'h2);
        ticks_to(122); check("s3_err_c122", {31'h0, align_error}, 0);
        check("s3_pulses", 32'(pulses[1]), 14);
        ticks_to(123); check("s3_err_c123", {31'h0, align_error}, 1);
        check("s3_err_lane", {30'h0, err_lane}, 1);
        ticks_to(132); check("s3_al_c132", {28'h0, lane_aligned}, 4'h5);
        ticks_to(133); check("s3_lane3", {30'h0, cur_lane}, 3);
        ticks_to(142); check("s3_busy", {31'h0, busy}, 0);
        check("s3_aligned", {28'h0, lane_aligned}, 4'hD);
        check("s3_all", {31'h0, all_aligned}, 0);
        check("s3_err_final", {31'h0, align_error}, 1);
        check("s3_err_lane_final", {30'h0, err_lane}, 1);

        // px_ready drops during a lane-3 WAIT
        set_lanes(0, 0, 0, 2, -1);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("s4_clr_err", {31'h0, align_error}, 0);
        check("s4_clr_err_lane", {30'h0, err_lane}, 0);
        new_run(3);
        ticks_to(30); check("s4_slip_c30", {28'h0, lane_slip}, 4'h8);
        ticks_to(32); check("s4_al_c32", {28'h0, lane_aligned}, 4'h7);
        check("s4_busy_c32", {31'h0, busy}, 1);
        px_ready = 1'b0;
        ticks_to(33);
        check("s4_ab_busy", {31'h0, busy}, 0);
        check("s4_ab_aligned", {28'h0, lane_aligned}, 0);
        check("s4_ab_slip", {28'h0, lane_slip}, 0);
        check("s4_ab_cur_lane", {30'h0, cur_lane}, 0);
        ticks_to(36); check("s4_hold_idle", {31'h0, busy}, 0);
        px_ready = 1'b1;
        new_run(3);
        ticks_to(1);  check("s4_restart_busy", {31'h0, busy}, 1);
        check("s4_restart_lane", {30'h0, cur_lane}, 0);
        ticks_to(44); check("s4_busy_c44", {31'h0, busy}, 1);
        ticks_to(45); check("s4_busy_c45", {31'h0, busy}, 0);
        check("s4_pulses", 32'(pulses[3]), 1);
        check("s4_all", {31'h0, all_aligned}, 1);

        // realign and abort in the same cycle from DONE
        realign = 1'b1; px_ready = 1'b0;
        tick();
        realign = 1'b0;
        check("s5_clr_aligned", {28'h0, lane_aligned}, 0);
        check("s5_clr_all", {31'h0, all_aligned}, 0);
        repeat (4) tick();
        check("s5_idle_busy", {31'h0, busy}, 0);
        check("s5_idle_aligned", {28'h0, lane_aligned}, 0);

        // async reset while a slip pulse is out
        set_lanes(1, 0, 0, 0, -1);
        px_ready = 1'b1;
        new_run(0);
        ticks_to(3);
        check("s6_slip_c3", {28'h0, lane_slip}, 4'h1);
        check("s6_busy_c3", {31'h0, busy}, 1);
        #2 px_reset = 1'b1;
        #1;
        check("s6_rst_slip", {28'h0, lane_slip}, 0);
        check("s6_rst_busy", {31'h0, busy}, 0);
        check("s6_rst_cur_lane", {30'h0, cur_lane}, 0);
        @(negedge clk);
        check("s6_rst_hold", {28'h0, lane_slip}, 0);
        px_reset = 1'b0; px_ready = 1'b0;
        @(negedge clk);
        check("s6_after_rst", {31'h0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
